// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Sequencer for a 2-to-4 enabled decoder. It scans the channels selected by
//   chan_mask in ascending order. Before each channel, e is held low for
//   BLANK_CYCLES cycles. Then e is held high for the dwell time. The select
//   pair only moves on the edge that takes e low (or while e is already low),
//   so the decoder never drives a wrong channel.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin scanning; only honoured while idle
//   stop            halt request; the current channel still completes its dwell
//   dwell           enable-high cycles per channel (0 treated as 1), sampled per frame
//   chan_mask       channel enable mask, sampled per frame
//   a1, a0          decoder select pair
//   e               decoder enable
//   busy            high whenever not idle
//   frame_done      one-cycle pulse after the last channel of a frame
module decoder_scan_ctrl #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         chan_mask,
  output logic               a1,
  output logic               a0,
  output logic               e,
  output logic               busy,
  output logic               frame_done
);

  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] BLANK_LOAD =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         addr_q, addr_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               pend_q, pend_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               fd_q, fd_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic               do_enter;
  logic [1:0]         enter_ch;
  logic [DWELL_W-1:0] enter_dw;
  logic [2:0]         above;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  // {found, index} of the lowest enabled channel strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = '0;
    if (m[3] && cur < 2'd3) r = {1'b1, 2'd3};
    if (m[2] && cur < 2'd2) r = {1'b1, 2'd2};
    if (m[1] && cur < 2'd1) r = {1'b1, 2'd1};
    return r;
  endfunction

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign above     = next_above(mask_q, addr_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    pend_d   = pend_q;
    fd_d     = 1'b0;
    do_enter = 1'b0;
    enter_ch = addr_q;
    enter_dw = dwell_q;

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (start && !stop && chan_mask != '0) begin
          mask_d   = chan_mask;
          dwell_d  = dwell_eff;
          do_enter = 1'b1;
          enter_ch = lowest_set(chan_mask);
          enter_dw = dwell_eff;
        end
      end

      S_BLANK: begin
        if (stop) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DWELL;
          cnt_d   = CNT_W'(dwell_q - DWELL_W'(1));
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DWELL: begin
        if (stop) pend_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pend_q || stop) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end else if (above[2]) begin
          do_enter = 1'b1;
          enter_ch = above[1:0];
          enter_dw = dwell_q;
        end else begin
          // Frame boundary: re-sample configuration for the next frame.
          fd_d    = 1'b1;
          mask_d  = chan_mask;
          dwell_d = dwell_eff;
          if (chan_mask == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            do_enter = 1'b1;
            enter_ch = lowest_set(chan_mask);
            enter_dw = dwell_eff;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Common channel entry: the address moves on the same edge that takes e low.
    if (do_enter) begin
      addr_d = enter_ch;
      if (HAS_BLANK) begin
        state_d = S_BLANK;
        cnt_d   = BLANK_LOAD;
      end else begin
        state_d = S_DWELL;
        cnt_d   = CNT_W'(enter_dw - DWELL_W'(1));
      end
    end

    e_d    = (state_d == S_DWELL);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      pend_q  <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      pend_q  <= pend_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign a1         = addr_q[1];
  assign a0         = addr_q[0];
  assign e          = e_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl. The reference model expands each frame
// into a queue of per-cycle output slots, one slot per cycle. Each slot holds
// the channel, the enable value and a flag marking the last dwell cycle.
// The bench compares the DUT against this model every cycle. It also runs
// table rows and directed sequences with hand-computed expectations.
module tb_decoder_scan_ctrl;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] dwell = '0;
  logic [3:0] chan_mask = '0;
  logic       a1, a0, e, busy, frame_done;

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dwell(dwell),
    .chan_mask(chan_mask), .a1(a1), .a0(a0), .e(e), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [1:0] addr; logic en; logic last; } slot_t;
  slot_t q[$];
  logic [1:0] m_addr = '0;
  logic m_e = 0, m_busy = 0, m_fd = 0, m_last = 0, m_pend = 0;
  logic [1:0] prev_addr = '0;

  typedef struct { logic [3:0] mask; logic [7:0] dw; int len; int ecnt; int first; } row_t;
  row_t rows[6];

  task automatic model_reset();
    q.delete();
    m_addr = '0; m_e = 0; m_busy = 0; m_fd = 0; m_last = 0; m_pend = 0;
  endtask

  task automatic model_build(input logic [3:0] m, input logic [7:0] d);
    int dd;
    dd = (d == 0) ? 1 : int'(d);
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k < BLANK; k++) q.push_back('{2'(ch), 1'b0, 1'b0});
        for (int k = 0; k < dd; k++) q.push_back('{2'(ch), 1'b1, (k == dd - 1)});
      end
    end
  endtask

  task automatic model_pop();
    slot_t s;
    s = q.pop_front();
    m_addr = s.addr; m_e = s.en; m_last = s.last; m_busy = 1;
  endtask

  task automatic model_idle();
    q.delete();
    m_e = 0; m_busy = 0; m_last = 0; m_pend = 0;
  endtask

  task automatic model_step();
    m_fd = 0;
    if (!m_busy) begin
      if (start && !stop && chan_mask != 0) begin
        model_build(chan_mask, dwell);
        model_pop();
      end
    end else begin
      if (stop) m_pend = 1;
      if (!m_last) model_pop();
      else if (m_pend) model_idle();
      else if (q.size() > 0) model_pop();
      else begin
        m_fd = 1;
        if (chan_mask == 0) model_idle();
        else begin
          model_build(chan_mask, dwell);
          model_pop();
        end
      end
    end
  endtask

  task automatic compare();
    checks++;
    if ({a1, a0, e, busy, frame_done} !== {m_addr, m_e, m_busy, m_fd}) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model cyc=%0d got a=%b e=%b busy=%b fd=%b required a=%b e=%b busy=%b fd=%b",
                 cyc, {a1, a0}, e, busy, frame_done, m_addr, m_e, m_busy, m_fd);
    end
    if (e === 1'b1) begin
      checks++;
      if ({a1, a0} !== prev_addr) begin
        errors++;
        if (errors <= 20)
          $display("FAIL addr_stable cyc=%0d got a=%b required a=%b", cyc, {a1, a0}, prev_addr);
      end
    end
    prev_addr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; stop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = '0;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk({name, "_timeout"}, n, 0);
  endtask

  initial begin
    int n, per, ecnt, first;
    logic [3:0] seen;

    rows[0] = '{4'b1111, 8'd3,   20,  12,  0};
    rows[1] = '{4'b1010, 8'd1,   6,   2,   1};
    rows[2] = '{4'b0001, 8'd0,   3,   1,   0};
    rows[3] = '{4'b1000, 8'd255, 257, 255, 3};
    rows[4] = '{4'b0110, 8'd2,   8,   4,   1};
    rows[5] = '{4'b0101, 8'd4,   12,  8,   0};

    // Reset state
    do_reset();
    #1;
    chk("reset_outs", int'({a1, a0, e, busy, frame_done}), 0);

    // Full scan timing with explicit cycle checks, then asynchronous reset mid-dwell
    chan_mask = 4'b1111; dwell = 8'd3; start = 1;
    tick(); start = 0;                                   // cycle 1
    chk("c1_addr_e", int'({a1, a0, e}), 0);
    tick(); tick();                                      // cycle 3
    chk("c3_addr_e", int'({a1, a0, e}), 1);
    repeat (3) tick();                                   // cycle 6
    chk("c6_addr_e", int'({a1, a0, e}), 2);
    repeat (14) tick();                                  // cycle 20
    chk("c20_fd", int'(frame_done), 0);
    tick();                                              // cycle 21
    chk("c21_fd", int'(frame_done), 1);
    repeat (3) tick();                                   // cycle 24, ch0 dwell
    chk("pre_reset_e", int'(e), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", int'({a1, a0, e, busy, frame_done}), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = '0;
    repeat (5) tick();
    chk("idle_after_reset", int'(busy), 0);

    // Table rows: first frame latency, frame period, enable cycles, first channel
    for (int r = 0; r < 6; r++) begin
      do_reset();
      chan_mask = rows[r].mask; dwell = rows[r].dw; start = 1;
      tick(); start = 0;
      n = 0;
      while (frame_done !== 1'b1 && n < 2000) begin tick(); n++; end
      chk($sformatf("row%0d_first_fd", r), n, rows[r].len);
      per = 0; ecnt = 0; first = -1;
      do begin
        tick(); per++;
        if (e === 1'b1) begin
          ecnt++;
          if (first < 0) first = int'({a1, a0});
        end
      end while (frame_done !== 1'b1 && per < 2000);
      chk($sformatf("row%0d_period", r), per, rows[r].len);
      chk($sformatf("row%0d_ecnt", r), ecnt, rows[r].ecnt);
      chk($sformatf("row%0d_first_ch", r), first, rows[r].first);
    end

    // start with empty mask is ignored; start with stop: stop wins
    do_reset();
    chan_mask = 4'b0000; dwell = 8'd2; start = 1;
    repeat (3) tick();
    chk("mask0_busy_e", int'({busy, e}), 0);
    chan_mask = 4'b1111; stop = 1;
    tick();
    chk("start_stop_busy", int'(busy), 0);
    start = 0; stop = 0;

    // Stop during first dwell cycle of channel 2
    do_reset();
    chan_mask = 4'b1111; dwell = 8'd4; start = 1;
    tick(); start = 0;                                   // cycle 1
    repeat (14) tick();                                  // cycle 15
    chk("stop_ch2_first", int'({a1, a0, e}), 5);
    stop = 1; tick(); stop = 0;                          // cycle 16
    tick(); tick();                                      // cycle 18
    chk("stop_still_dwell", int'({a1, a0, e, busy}), 11);
    tick();                                              // cycle 19
    chk("stop_idle", int'({a1, a0, e, busy, frame_done}), 16);
    repeat (4) tick();

    // Mid-frame reconfiguration only takes effect at the frame boundary
    do_reset();
    chan_mask = 4'b1111; dwell = 8'd2; start = 1;
    tick(); start = 0;                                   // cycle 1
    repeat (6) tick();                                   // cycle 7, ch1 dwell
    chan_mask = 4'b0001;
    seen = '0;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      if (e === 1'b1) seen[{a1, a0}] = 1'b1;
      tick(); n++;
    end
    chk("reconfig_seen", int'(seen), 4'b1110);
    seen = '0;
    repeat (12) begin
      tick();
      if (e === 1'b1) seen[{a1, a0}] = 1'b1;
    end
    chk("reconfig_after", int'(seen), 4'b0001);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) chan_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 4));
      tick();
    end
    start = 0; stop = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Upstream sequencer for the 2-to-4 enabled decoder. It drives the decoder's select pair (a1,a0) and enable (e) to scan four output channels in turn. Each channel gets a programmable dwell time, with enable-low blanking between channels. The select pair changes only while e is low, so decoder outputs never glitch onto the wrong channel. Used for display digit / row scanning.

Parameters:
DWELL_W, 8, width of the dwell-time input in clock cycles
BLANK_CYCLES, 2, cycles e is held low before each channel's dwell (0 allowed = no blanking)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scanning (level sampled; acted on only in IDLE)
stop  input  1  request halt; latched as pending
dwell  input  DWELL_W  enable-high cycles per channel; sampled at frame start
chan_mask  input  4  bit i=1 means channel i is scanned; sampled at frame start
a1  output  1  select MSB to decoder
a0  output  1  select LSB to decoder
e  output  1  decoder enable
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the last enabled channel's dwell

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered.
- Reset (async assert, any state): a1=0, a0=0, e=0, busy=0, frame_done=0, stop_pending=0, state=IDLE, counters=0. Release is synchronous to clk.
- FSM states: IDLE, BLANK, DWELL.
- IDLE:
  - e=0; {a1,a0} hold their last value.
  - start=1, stop=0 and chan_mask!=0 -> latch mask_q=chan_mask and dwell_q=(dwell==0 ? 1 : dwell).
  - Set {a1,a0} to the lowest set bit of mask_q, then go to BLANK (or DWELL if BLANK_CYCLES=0).
  - start with chan_mask==0 is ignored. start and stop in the same cycle: stop wins, remain IDLE.
- BLANK: e=0 for exactly BLANK_CYCLES cycles with the address already at the target channel, then go to DWELL.
- DWELL: e=1 for exactly dwell_q cycles. On the last dwell cycle:
  - stop_pending or stop=1 -> IDLE, clear stop_pending, e=0 next cycle, address holds.
  - Else if a higher-indexed bit is set in mask_q -> move the address to that channel, then BLANK.
  - Else (frame end) -> pulse frame_done for 1 cycle, re-latch chan_mask/dwell (same zero rules), move the address to the lowest enabled channel, then BLANK. If the newly sampled chan_mask==0 -> IDLE instead (frame_done still pulses).
- Invariant: {a1,a0} never change in a cycle where e=1 either before or after the edge. The address updates in the same edge that drops e.
- stop asserted in BLANK or DWELL sets stop_pending. The current channel always completes its dwell; the scan never truncates mid-dwell.
- start while busy is ignored. Changes to dwell/chan_mask mid-frame have no effect until the next frame boundary.
- Per-channel period = BLANK_CYCLES + dwell_q. Frame period = popcount(mask_q) * per-channel period.
- Dwell counter width is DWELL_W. The max value 2^DWELL_W-1 must work without wrap.

Test Plan:
1. Reset: hold rst_n=0 mid-DWELL with e=1 -> e, a1, a0, busy, frame_done go 0 immediately (asynchronously). After release, remains IDLE with no start.
2. Full scan, mask=4'b1111, dwell=3, BLANK_CYCLES=2, start pulse sampled at edge 0:
   - Cycles 1-2: addr=00, e=0. Cycles 3-5: addr=00, e=1. Cycles 6-7: addr=01, e=0.
   - Frame repeats every 20 cycles. frame_done is high only in cycle 21.
   - Checker confirms the address never changes while e=1.
3. Skip mask, mask=4'b1010, dwell=1: e=1 visits only addr 01 and 11, alternating. Frame = 6 cycles. frame_done pulses once per frame.
4. Zero inputs:
   - dwell=0 -> e=1 for exactly 1 cycle per channel.
   - start with mask=0 -> busy stays 0, e stays 0.
5. Stop: assert stop for one cycle during the first dwell cycle of channel 2 (dwell=4). Channel 2 completes all 4 enable cycles, then e=0, busy=0 next cycle, addr holds 10, no frame_done.
6. Mid-frame reconfig: change mask 1111->0001 during channel 1's dwell. Channels 2 and 3 are still scanned. After frame_done, only addr 00 is enabled.
